// File: rtl/pll_post_div_pkg.sv
// Shared types and the config clamp for the PLL post-divider bank.
// Config fields are carried at CFG_W_MAX bits. Each channel keeps only its DIV_W low bits,
// so DIV_W must not exceed CFG_W_MAX.
package pll_post_div_pkg;

    localparam int unsigned CFG_W_MAX = 32;

    typedef enum logic [1:0] {
        StIdle,
        StPhase,
        StRun
    } post_div_state_t;

    typedef struct packed {
        logic [CFG_W_MAX-1:0] div;
        logic [CFG_W_MAX-1:0] high;
        logic [CFG_W_MAX-1:0] phase;
    } post_div_cfg_t;

    // Force a legal ratio and a non-degenerate duty cycle; phase passes through.
    function automatic post_div_cfg_t post_div_clamp(input post_div_cfg_t c);
        post_div_cfg_t r;
        r = c;
        if (r.div < CFG_W_MAX'(2)) begin
            r.div = CFG_W_MAX'(2);
        end
        if (r.high == '0) begin
            r.high = CFG_W_MAX'(1);
        end else if (r.high >= r.div) begin
            r.high = r.div - CFG_W_MAX'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_post_div_channel.sv
// One post-divider channel: IDLE -> PHASE -> RUN FSM with active and shadow config.
// Optional output sync_pulse when PLL_POST_DIV_SYNC_PULSE_EN is defined.
module pll_post_div_channel
    import pll_post_div_pkg::*;
#(
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DEF_DIV   = 2,
    parameter int unsigned DEF_HIGH  = 1,
    parameter int unsigned DEF_PHASE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          wr,
    input  post_div_cfg_t wr_cfg,
    output logic          cout,
    output logic          busy
`ifdef PLL_POST_DIV_SYNC_PULSE_EN
    ,
    output logic          sync_pulse
`endif
);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] high;
        logic [DIV_W-1:0] phase;
    } ch_cfg_t;

    localparam ch_cfg_t DefCfg = '{
        div:   DIV_W'(DEF_DIV),
        high:  DIV_W'(DEF_HIGH),
        phase: DIV_W'(DEF_PHASE)
    };

    post_div_state_t  state_q, state_d;
    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    ch_cfg_t          act_q, act_d;
    ch_cfg_t          shd_q, shd_d;
    ch_cfg_t          in_cfg;
    logic             wrap;

    // Clamped values already fit in DIV_W bits; the upper bits are always zero.
    assign in_cfg = '{
        div:   wr_cfg.div[DIV_W-1:0],
        high:  wr_cfg.high[DIV_W-1:0],
        phase: wr_cfg.phase[DIV_W-1:0]
    };

    if (DIV_W < CFG_W_MAX) begin : g_unused
        logic unused_cfg_bits;
        assign unused_cfg_bits = ^{wr_cfg.div[CFG_W_MAX-1:DIV_W], wr_cfg.high[CFG_W_MAX-1:DIV_W],
                                   wr_cfg.phase[CFG_W_MAX-1:DIV_W]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; en=0 always drops back to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StPhase;
            StPhase: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (pcnt_q == '0) begin
                    state_d = StRun;
                end
            end
            StRun:   if (!en) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counters, registered clock output and active/shadow config update.
    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        cout_d = 1'b0;
        busy_d = busy_q;
        act_d  = act_q;
        shd_d  = shd_q;
        wrap   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A write on the enabling edge is active immediately, including its phase.
                if (en) pcnt_d = wr ? in_cfg.phase : act_q.phase;
            end
            StPhase: begin
                if (en) begin
                    if (pcnt_q == '0) begin
                        cnt_d  = DIV_W'(1);
                        cout_d = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q - DIV_W'(1);
                    end
                end
            end
            StRun: begin
                if (en) begin
                    if (cnt_q == act_q.div) begin
                        wrap   = 1'b1;
                        cnt_d  = DIV_W'(1);
                        cout_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + DIV_W'(1);
                        cout_d = (cnt_d <= act_q.high);
                    end
                end
            end
            default: ;
        endcase
        // Pending config lands at a period boundary or when the channel stops.
        if (busy_q && (wrap || !en)) begin
            act_d  = shd_q;
            busy_d = 1'b0;
        end
        // A new write after the boundary apply, so it wins over the old shadow.
        if (wr) begin
            if (state_q == StIdle || !en) begin
                act_d  = in_cfg;
                busy_d = 1'b0;
            end else begin
                shd_d  = in_cfg;
                busy_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            act_q  <= DefCfg;
            shd_q  <= DefCfg;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            cout_q <= cout_d;
            busy_q <= busy_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
        end
    end

    assign cout = cout_q;
    assign busy = busy_q;

`ifdef PLL_POST_DIV_SYNC_PULSE_EN
    logic sync_q;

    // One-cycle pulse aligned with every registered 0->1 of cout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= cout_d & ~cout_q;
        end
    end

    assign sync_pulse = sync_q;
`endif

endmodule

// File: rtl/pll_post_divider_bank.sv
// Multi-channel programmable post-divider: config handshake decode plus NUM_CH channels.
// Optional output sync_pulse when PLL_POST_DIV_SYNC_PULSE_EN is defined.
module pll_post_divider_bank
    import pll_post_div_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DEF_DIV   = 2,
    parameter int unsigned DEF_HIGH  = 1,
    parameter int unsigned DEF_PHASE = 0,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] cout,
    output logic [NUM_CH-1:0] busy
`ifdef PLL_POST_DIV_SYNC_PULSE_EN
    ,
    output logic [NUM_CH-1:0] sync_pulse
`endif
);

    logic [NUM_CH-1:0] wr;
    post_div_cfg_t     wr_cfg;

    // Ready mirrors the target channel's busy; out-of-range channels are always ready.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_chan == CH_W'(i)) cfg_ready = ~busy[i];
        end
    end

    // Accepted write strobes; an out-of-range channel matches nothing and is dropped.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_valid && cfg_ready && (cfg_chan == CH_W'(i));
        end
    end

    // Clamp once here; every channel sees the same clamped payload.
    always_comb begin
        wr_cfg = post_div_clamp('{
            div:   CFG_W_MAX'(cfg_div),
            high:  CFG_W_MAX'(cfg_high),
            phase: CFG_W_MAX'(cfg_phase)
        });
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pll_post_div_channel #(
            .DIV_W     (DIV_W),
            .DEF_DIV   (DEF_DIV),
            .DEF_HIGH  (DEF_HIGH),
            .DEF_PHASE (DEF_PHASE)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .en     (en[g]),
            .wr     (wr[g]),
            .wr_cfg (wr_cfg),
            .cout   (cout[g]),
            .busy   (busy[g])
`ifdef PLL_POST_DIV_SYNC_PULSE_EN
            ,
            .sync_pulse (sync_pulse[g])
`endif
        );
    end

endmodule
